// File: rtl/dut_vector_sequencer.sv
// Streams buffered stimulus vectors into a combinational DUT, waits a settle interval,
// and returns each sampled response on a valid/ready channel. Optional: RESULT_CHECK_EN.
module dut_vector_sequencer #(
  parameter int unsigned IN_W          = 150,
  parameter int unsigned OUT_W         = 80,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned IDX_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stim_valid,
  output logic             stim_ready,
  input  logic [IN_W-1:0]  stim_data,
  input  logic             stim_last,
`ifdef RESULT_CHECK_EN
  input  logic [OUT_W-1:0] exp_data,
  output logic [IDX_W-1:0] mismatch_cnt,
  output logic             res_mismatch,
`endif
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [OUT_W-1:0] res_data,
  output logic [IDX_W-1:0] res_index,
  output logic             res_last,
  output logic             busy,
  output logic             done
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
`ifdef RESULT_CHECK_EN
  localparam int unsigned ENT_W = OUT_W + IN_W + 1;
`else
  localparam int unsigned ENT_W = IN_W + 1;
`endif
  localparam logic [3:0]       SETTLE_INIT = 4'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);
  localparam logic [AW:0]      PTR_ONE     = (AW + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_CAPTURE,
    S_EMIT
  } state_t;

  // Stimulus FIFO; pointers carry one extra bit to separate full from empty
  logic [ENT_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [ENT_W-1:0] w_push_entry;
  logic [ENT_W-1:0] w_head;
  logic [IN_W-1:0]  w_head_data;
  logic             w_head_last;
`ifdef RESULT_CHECK_EN
  logic [OUT_W-1:0] w_head_exp;
`endif

  state_t           r_state;
  logic [IN_W-1:0]  r_dut_in;
  logic             r_last_lat;
  logic [3:0]       r_settle_cnt;
  logic             r_res_valid;
  logic [OUT_W-1:0] r_res_data;
  logic [IDX_W-1:0] r_res_index;
  logic             r_res_last;
  logic [IDX_W-1:0] r_vec_idx;
  logic             r_done;
`ifdef RESULT_CHECK_EN
  logic [OUT_W-1:0] r_exp_lat;
  logic             r_res_mismatch;
  logic [IDX_W-1:0] r_mismatch_cnt;
`endif

  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_push  = stim_valid && !w_full;
  assign w_pop   = (r_state == S_APPLY);

`ifdef RESULT_CHECK_EN
  assign w_push_entry = {exp_data, stim_last, stim_data};
`else
  assign w_push_entry = {stim_last, stim_data};
`endif

  assign w_head      = r_mem[r_rd_ptr[AW-1:0]];
  assign w_head_data = w_head[IN_W-1:0];
  assign w_head_last = w_head[IN_W];
`ifdef RESULT_CHECK_EN
  assign w_head_exp  = w_head[ENT_W-1 -: OUT_W];
`endif

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= w_push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_dut_in       <= '0;
      r_last_lat     <= 1'b0;
      r_settle_cnt   <= '0;
      r_res_valid    <= 1'b0;
      r_res_data     <= '0;
      r_res_index    <= '0;
      r_res_last     <= 1'b0;
      r_vec_idx      <= '0;
      r_done         <= 1'b0;
`ifdef RESULT_CHECK_EN
      r_exp_lat      <= '0;
      r_res_mismatch <= 1'b0;
      r_mismatch_cnt <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_state <= S_APPLY;
          end
        end
        S_APPLY: begin
          r_dut_in     <= w_head_data;
          r_last_lat   <= w_head_last;
`ifdef RESULT_CHECK_EN
          r_exp_lat    <= w_head_exp;
`endif
          r_settle_cnt <= SETTLE_INIT;
          r_state      <= S_SETTLE;
        end
        S_SETTLE: begin
          if (r_settle_cnt == '0) begin
            r_state <= S_CAPTURE;
          end else begin
            r_settle_cnt <= r_settle_cnt - 4'd1;
          end
        end
        S_CAPTURE: begin
          r_res_data     <= dut_out;
          r_res_index    <= r_vec_idx;
          r_res_last     <= r_last_lat;
          r_res_valid    <= 1'b1;
`ifdef RESULT_CHECK_EN
          r_res_mismatch <= (dut_out != r_exp_lat);
`endif
          r_state        <= S_EMIT;
        end
        S_EMIT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
`ifdef RESULT_CHECK_EN
            if (r_res_mismatch && (r_mismatch_cnt != '1)) begin
              r_mismatch_cnt <= r_mismatch_cnt + IDX_ONE;
            end
`endif
            // the last result of a run restarts numbering for the next run
            if (r_res_last) begin
              r_done    <= 1'b1;
              r_vec_idx <= '0;
              r_state   <= S_IDLE;
            end else begin
              r_vec_idx <= r_vec_idx + IDX_ONE;
              r_state   <= w_empty ? S_IDLE : S_APPLY;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stim_ready = !w_full;
  assign dut_in     = r_dut_in;
  assign res_valid  = r_res_valid;
  assign res_data   = r_res_data;
  assign res_index  = r_res_index;
  assign res_last   = r_res_last;
  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;
`ifdef RESULT_CHECK_EN
  assign res_mismatch = r_res_mismatch;
  assign mismatch_cnt = r_mismatch_cnt;
`endif

endmodule

// File: tb/tb_dut_vector_sequencer.sv
// Directed bench: two sequencer instances (default settings, and SETTLE_CYCLES=5 / IDX_W=4)
// each driving a DUT model whose output is dut_in[100:21].
`timescale 1ns/1ps
module tb_dut_vector_sequencer;
  localparam int unsigned IN_W  = 150;
  localparam int unsigned OUT_W = 80;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic             a_stim_valid, a_stim_ready, a_stim_last;
  logic [IN_W-1:0]  a_stim_data, a_dut_in;
  logic [OUT_W-1:0] a_dut_out, a_res_data;
  logic             a_res_valid, a_res_ready, a_res_last, a_busy, a_done;
  logic [15:0]      a_res_index;

  logic             b_stim_valid, b_stim_ready, b_stim_last;
  logic [IN_W-1:0]  b_stim_data, b_dut_in;
  logic [OUT_W-1:0] b_dut_out, b_res_data;
  logic             b_res_valid, b_res_ready, b_res_last, b_busy, b_done;
  logic [3:0]       b_res_index;

`ifdef RESULT_CHECK_EN
  logic [OUT_W-1:0] a_exp_data, b_exp_data;
  logic [15:0]      a_mismatch_cnt;
  logic [3:0]       b_mismatch_cnt;
  logic             a_res_mismatch, b_res_mismatch;
`endif

  assign a_dut_out = a_dut_in[100:21];
  assign b_dut_out = b_dut_in[100:21];

  dut_vector_sequencer #(
    .IN_W(IN_W), .OUT_W(OUT_W), .SETTLE_CYCLES(1), .FIFO_DEPTH(4), .IDX_W(16)
  ) u_dut_a (
    .clk(clk), .rst(rst),
    .stim_valid(a_stim_valid), .stim_ready(a_stim_ready),
    .stim_data(a_stim_data), .stim_last(a_stim_last),
`ifdef RESULT_CHECK_EN
    .exp_data(a_exp_data), .mismatch_cnt(a_mismatch_cnt), .res_mismatch(a_res_mismatch),
`endif
    .dut_in(a_dut_in), .dut_out(a_dut_out),
    .res_valid(a_res_valid), .res_ready(a_res_ready),
    .res_data(a_res_data), .res_index(a_res_index), .res_last(a_res_last),
    .busy(a_busy), .done(a_done)
  );

  dut_vector_sequencer #(
    .IN_W(IN_W), .OUT_W(OUT_W), .SETTLE_CYCLES(5), .FIFO_DEPTH(4), .IDX_W(4)
  ) u_dut_b (
    .clk(clk), .rst(rst),
    .stim_valid(b_stim_valid), .stim_ready(b_stim_ready),
    .stim_data(b_stim_data), .stim_last(b_stim_last),
`ifdef RESULT_CHECK_EN
    .exp_data(b_exp_data), .mismatch_cnt(b_mismatch_cnt), .res_mismatch(b_res_mismatch),
`endif
    .dut_in(b_dut_in), .dut_out(b_dut_out),
    .res_valid(b_res_valid), .res_ready(b_res_ready),
    .res_data(b_res_data), .res_index(b_res_index), .res_last(b_res_last),
    .busy(b_busy), .done(b_done)
  );

  task automatic chk(input string tag, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  logic [IN_W-1:0]  a_vec, b_vec;
  logic [OUT_W-1:0] e80;
  int unsigned      lat;
  int unsigned      w;

  initial begin
    rst = 1'b1;
    a_stim_valid = 1'b0; a_stim_data = '0; a_stim_last = 1'b0; a_res_ready = 1'b0;
    b_stim_valid = 1'b0; b_stim_data = '0; b_stim_last = 1'b0; b_res_ready = 1'b0;
`ifdef RESULT_CHECK_EN
    a_exp_data = '0; b_exp_data = '0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_res_valid", a_res_valid, 0);
    chk("rst_res_data", a_res_data, 0);
    chk("rst_res_index", a_res_index, 0);
    chk("rst_res_last", a_res_last, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_dut_in", a_dut_in, 0);
    chk("rst_stim_ready", a_stim_ready, 1);
    rst = 1'b0;

    // single vector: in[100] -> out[79], latency SETTLE_CYCLES+3 = 4
    a_vec = '0; a_vec[100] = 1'b1;
    a_res_ready = 1'b1;
    a_stim_valid = 1'b1; a_stim_data = a_vec; a_stim_last = 1'b1;
    @(negedge clk);
    a_stim_valid = 1'b0; a_stim_last = 1'b0;
    lat = 0;
    while (!a_res_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("t1_latency", lat, 4);
    e80 = '0; e80[79] = 1'b1;
    chk("t1_res_data", a_res_data, e80);
    chk("t1_res_index", a_res_index, 0);
    chk("t1_res_last", a_res_last, 1);
    chk("t1_busy", a_busy, 1);
    chk("t1_done_early", a_done, 0);
    @(negedge clk);
    chk("t1_done", a_done, 1);
    chk("t1_valid_drop", a_res_valid, 0);
    chk("t1_idle", a_busy, 0);
    @(negedge clk);
    chk("t1_done_pulse", a_done, 0);
    chk("t1_dut_in_hold", a_dut_in, a_vec);

    // backpressure: 6 vectors with res_ready low
    a_res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a_stim_valid = 1'b1; a_stim_data = IN_W'(i + 1) << 21; a_stim_last = 1'b0;
      w = 0;
      while (!a_stim_ready && w < 40) begin
        @(negedge clk);
        w++;
      end
      chk("t2_ready_wait", w, 0);
      @(negedge clk);
    end
    a_stim_data = IN_W'(6) << 21; a_stim_last = 1'b1;
    chk("t2_full", a_stim_ready, 0);
    for (int k = 0; k < 3; k++) begin
      chk("t2_hold_valid", a_res_valid, 1);
      chk("t2_hold_data", a_res_data, 80'd1);
      chk("t2_hold_index", a_res_index, 0);
      @(negedge clk);
    end
    chk("t2_still_full", a_stim_ready, 0);
    a_res_ready = 1'b1;
    fork
      begin
        int unsigned w5;
        w5 = 0;
        while (!a_stim_ready && w5 < 60) begin
          @(negedge clk);
          w5++;
        end
        chk("t2_push6_ready", a_stim_ready, 1);
        @(negedge clk);
        a_stim_valid = 1'b0; a_stim_last = 1'b0;
      end
      begin
        for (int k = 0; k < 6; k++) begin
          int unsigned w2;
          w2 = 0;
          while (!a_res_valid && w2 < 60) begin
            @(negedge clk);
            w2++;
          end
          chk("t2_valid", a_res_valid, 1);
          chk("t2_index", a_res_index, k);
          chk("t2_data", a_res_data, k + 1);
          chk("t2_last", a_res_last, (k == 5) ? 1 : 0);
          @(negedge clk);
        end
        chk("t2_done", a_done, 1);
      end
    join

    // settle length 5 on instance B: latency 8, dut_in stable from APPLY
    b_vec = IN_W'(80'hDEAD_BEEF) << 21;
    b_res_ready = 1'b1;
    b_stim_valid = 1'b1; b_stim_data = b_vec; b_stim_last = 1'b0;
    @(negedge clk);
    b_stim_valid = 1'b0;
    lat = 0;
    while (!b_res_valid && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat >= 2 && !b_res_valid) chk("t3_dut_in_stable", b_dut_in, b_vec);
    end
    chk("t3_latency", lat, 8);
    chk("t3_res_data", b_res_data, 80'hDEAD_BEEF);
    chk("t3_res_index", b_res_index, 0);
    chk("t3_res_last", b_res_last, 0);
    @(negedge clk);
    chk("t3_valid_drop", b_res_valid, 0);
    chk("t3_no_done", b_done, 0);
    chk("t3_idle", b_busy, 0);

    // mid-run reset during SETTLE (B index is 1 at this point)
    b_stim_valid = 1'b1; b_stim_data = IN_W'(80'h1234) << 21; b_stim_last = 1'b1;
    @(negedge clk);
    b_stim_valid = 1'b0; b_stim_last = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4_busy_settle", b_busy, 1);
    chk("t4_dut_in_applied", b_dut_in, IN_W'(80'h1234) << 21);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t4_busy", b_busy, 0);
    chk("t4_res_valid", b_res_valid, 0);
    chk("t4_stim_ready", b_stim_ready, 1);
    chk("t4_dut_in", b_dut_in, 0);
    b_stim_valid = 1'b1; b_stim_data = IN_W'(80'h55) << 21; b_stim_last = 1'b1;
    @(negedge clk);
    b_stim_valid = 1'b0; b_stim_last = 1'b0;
    w = 0;
    while (!b_res_valid && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("t4_valid", b_res_valid, 1);
    chk("t4_index", b_res_index, 0);
    chk("t4_data", b_res_data, 80'h55);
    @(negedge clk);
    chk("t4_done", b_done, 1);

    // index wrap on B (IDX_W=4): 17 vectors -> 0..15, 0
    fork
      begin
        for (int i = 0; i < 17; i++) begin
          int unsigned wp;
          b_stim_valid = 1'b1; b_stim_data = IN_W'(i + 1) << 21; b_stim_last = (i == 16);
          wp = 0;
          while (!b_stim_ready && wp < 100) begin
            @(negedge clk);
            wp++;
          end
          @(negedge clk);
        end
        b_stim_valid = 1'b0; b_stim_last = 1'b0;
      end
      begin
        for (int k = 0; k < 17; k++) begin
          int unsigned wc;
          wc = 0;
          while (!b_res_valid && wc < 100) begin
            @(negedge clk);
            wc++;
          end
          chk("t5_valid", b_res_valid, 1);
          chk("t5_index", b_res_index, k % 16);
          chk("t5_data", b_res_data, k + 1);
          chk("t5_last", b_res_last, (k == 16) ? 1 : 0);
          @(negedge clk);
          if (k < 16) chk("t5_no_done", b_done, 0);
        end
        chk("t5_done", b_done, 1);
      end
    join

`ifdef RESULT_CHECK_EN
    // expected-data compare on A; its counter was cleared by the reset above
    a_res_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a_stim_valid = 1'b1; a_stim_data = '0; a_stim_last = (i == 1);
      a_exp_data = '0;
      if (i == 1) a_exp_data[60] = 1'b1;
      w = 0;
      while (!a_stim_ready && w < 40) begin
        @(negedge clk);
        w++;
      end
      @(negedge clk);
    end
    a_stim_valid = 1'b0; a_stim_last = 1'b0; a_exp_data = '0;
    for (int k = 0; k < 2; k++) begin
      w = 0;
      while (!a_res_valid && w < 40) begin
        @(negedge clk);
        w++;
      end
      chk("t6_valid", a_res_valid, 1);
      chk("t6_mismatch", a_res_mismatch, k);
      @(negedge clk);
      chk("t6_cnt", a_mismatch_cnt, k);
    end
    chk("t6_done", a_done, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
